// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Instruction-memory request/response bus between fetch and imem.
// Revision : 1.0
// ============================================================================
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch with one outstanding imem request, IF/ID
//            register, stall hold buffer and redirect/flush handling.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        stall,
    input  wire logic        redirect,
    input  wire logic [31:0] redirect_pc,
    fetch_stage_if.master    imem,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DROP  = 3'd4
    } state_t;

    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] c_RESET_PC   = RESET_PC & c_ALIGN_MASK;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_hold_buf;
    logic [31:0] w_hold_buf_next;
    logic [31:0] r_if_id_pc;
    logic [31:0] w_if_id_pc_next;
    logic [31:0] r_if_id_instr;
    logic [31:0] w_if_id_instr_next;
    logic        r_if_id_valid;
    logic        w_if_id_valid_next;

    logic        w_req;
    logic        w_deliver;
    logic [31:0] w_deliver_instr;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_inc;

    assign w_redirect_pc = redirect_pc & c_ALIGN_MASK;
    assign w_pc_inc      = r_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= c_RESET_PC;
            r_hold_buf    <= 32'd0;
            r_if_id_pc    <= 32'd0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_hold_buf    <= w_hold_buf_next;
            r_if_id_pc    <= w_if_id_pc_next;
            r_if_id_instr <= w_if_id_instr_next;
            r_if_id_valid <= w_if_id_valid_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_hold_buf_next = r_hold_buf;
        w_req           = 1'b0;
        w_deliver       = 1'b0;
        w_deliver_instr = r_hold_buf;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_req = 1'b1;
                if (imem.imem_ready) begin
                    // An accepted request for a stale address must have its response dropped.
                    w_state_next = redirect ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (redirect) begin
                        w_state_next = S_ISSUE;
                    end else if (stall) begin
                        w_deliver       = 1'b1;
                        w_deliver_instr = imem.imem_rdata;
                        w_pc_next       = w_pc_inc;
                        w_state_next    = S_ISSUE;
                    end else begin
                        w_hold_buf_next = imem.imem_rdata;
                        w_state_next    = S_HOLD;
                    end
                end else if (redirect) begin
                    w_state_next = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_state_next = S_ISSUE;
                end else if (stall) begin
                    w_deliver       = 1'b1;
                    w_deliver_instr = r_hold_buf;
                    w_pc_next       = w_pc_inc;
                    w_state_next    = S_ISSUE;
                end
            end
            S_DROP: begin
                if (imem.imem_rvalid) begin
                    w_state_next = S_ISSUE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // A redirect retargets the fetch pc from any state.
        if (redirect) begin
            w_pc_next = w_redirect_pc;
        end
    end

    // IF/ID: flush wins over stall; stall=0 freezes the register.
    always_comb begin
        w_if_id_pc_next    = r_if_id_pc;
        w_if_id_instr_next = r_if_id_instr;
        w_if_id_valid_next = r_if_id_valid;
        if (redirect) begin
            w_if_id_instr_next = NOP_INSTR;
            w_if_id_valid_next = 1'b0;
        end else if (w_deliver) begin
            w_if_id_pc_next    = r_pc;
            w_if_id_instr_next = w_deliver_instr;
            w_if_id_valid_next = 1'b1;
        end else if (stall) begin
            w_if_id_instr_next = NOP_INSTR;
            w_if_id_valid_next = 1'b0;
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign if_id_pc       = r_if_id_pc;
    assign if_id_instr    = r_if_id_instr;
    assign if_id_valid    = r_if_id_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed self-checking bench for fetch_stage.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    int n_tests;
    int n_fail;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (c_NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus.master),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
        bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
        step(); step();
        n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", if_id_valid); end
        n_tests++; if (if_id_instr !== c_NOP) begin n_fail++; $display("FAIL rst_instr got %h exp %h", if_id_instr, c_NOP); end
        n_tests++; if (if_id_pc !== 32'd0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", if_id_pc); end
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
        rst_n = 1'b1;
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b exp 0", bus.imem_req); end
        step();
        n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got %b exp 1", bus.imem_req); end
        n_tests++; if (bus.imem_addr !== 32'd0) begin n_fail++; $display("FAIL first_addr got %h exp 0", bus.imem_addr); end
    endtask

    task automatic test_sequential();
        step();
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_wait_req got %b exp 0", bus.imem_req); end
        n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL seq_bubble0 got %b exp 0", if_id_valid); end
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA000_0001;
        step();
        n_tests++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_v0 got %b exp 1", if_id_valid); end
        n_tests++; if (if_id_instr !== 32'hA000_0001) begin n_fail++; $display("FAIL seq_i0 got %h exp a0000001", if_id_instr); end
        n_tests++; if (if_id_pc !== 32'd0) begin n_fail++; $display("FAIL seq_p0 got %h exp 0", if_id_pc); end
        n_tests++; if (bus.imem_addr !== 32'd4 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_addr4 got %h/%b exp 4/1", bus.imem_addr, bus.imem_req); end
        bus.imem_rvalid = 1'b0;
        step();
        n_tests++; if (if_id_valid !== 1'b0 || if_id_instr !== c_NOP) begin n_fail++; $display("FAIL seq_bubble1 got %b/%h exp 0/%h", if_id_valid, if_id_instr, c_NOP); end
        n_tests++; if (if_id_pc !== 32'd0) begin n_fail++; $display("FAIL seq_bubble_pc got %h exp 0", if_id_pc); end
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA000_0002;
        step();
        n_tests++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hA000_0002 || if_id_pc !== 32'd4) begin n_fail++; $display("FAIL seq_1 got %b/%h/%h exp 1/a0000002/4", if_id_valid, if_id_instr, if_id_pc); end
        n_tests++; if (bus.imem_addr !== 32'd8) begin n_fail++; $display("FAIL seq_addr8 got %h exp 8", bus.imem_addr); end
        bus.imem_rvalid = 1'b0;
        step();
    endtask

    task automatic test_hold();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_2222; stall = 1'b0;
        step();
        n_tests++; if (if_id_valid !== 1'b0 || if_id_pc !== 32'd4) begin n_fail++; $display("FAIL hold_unch got %b/%h exp 0/4", if_id_valid, if_id_pc); end
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req got %b exp 0", bus.imem_req); end
        bus.imem_rvalid = 1'b0;
        step();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
        step();
        n_tests++; if (if_id_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_stay got %b/%b exp 0/0", if_id_valid, bus.imem_req); end
        bus.imem_rvalid = 1'b0; stall = 1'b1;
        step();
        n_tests++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h1111_2222 || if_id_pc !== 32'd8) begin n_fail++; $display("FAIL hold_release got %b/%h/%h exp 1/11112222/8", if_id_valid, if_id_instr, if_id_pc); end
        n_tests++; if (bus.imem_addr !== 32'd12 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL hold_addr got %h/%b exp c/1", bus.imem_addr, bus.imem_req); end
        step();
    endtask

    task automatic test_redirect_wait();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        n_tests++; if (bus.imem_req !== 1'b0 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL drop_enter got %b/%b exp 0/0", bus.imem_req, if_id_valid); end
        redirect = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        n_tests++; if (if_id_valid !== 1'b0 || if_id_instr !== c_NOP) begin n_fail++; $display("FAIL drop_discard got %b/%h exp 0/%h", if_id_valid, if_id_instr, c_NOP); end
        n_tests++; if (bus.imem_addr !== 32'h0000_0100 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL drop_addr got %h/%b exp 100/1", bus.imem_addr, bus.imem_req); end
        bus.imem_rvalid = 1'b0;
        step();
    endtask

    task automatic test_flush_beats_stall();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hC000_0000;
        step();
        bus.imem_rvalid = 1'b0; stall = 1'b0;
        step();
        n_tests++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hC000_0000 || if_id_pc !== 32'h100) begin n_fail++; $display("FAIL flush_pre got %b/%h/%h exp 1/c0000000/100", if_id_valid, if_id_instr, if_id_pc); end
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hC000_0001; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        n_tests++; if (if_id_valid !== 1'b0 || if_id_instr !== c_NOP) begin n_fail++; $display("FAIL flush_bubble got %b/%h exp 0/%h", if_id_valid, if_id_instr, c_NOP); end
        n_tests++; if (if_id_pc !== 32'h100) begin n_fail++; $display("FAIL flush_pc got %h exp 100", if_id_pc); end
        n_tests++; if (bus.imem_addr !== 32'h200 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL flush_addr got %h/%b exp 200/1", bus.imem_addr, bus.imem_req); end
        redirect = 1'b0; bus.imem_rvalid = 1'b0; stall = 1'b1;
    endtask

    task automatic test_wrap();
        bus.imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        n_tests++; if (bus.imem_addr !== 32'hFFFF_FFFC || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_redir got %h/%b exp fffffffc/1", bus.imem_addr, bus.imem_req); end
        redirect = 1'b0; bus.imem_ready = 1'b1;
        step();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hE000_0000;
        step();
        n_tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hFFFF_FFFC || if_id_instr !== 32'hE000_0000) begin n_fail++; $display("FAIL wrap_ifid got %b/%h/%h exp 1/fffffffc/e0000000", if_id_valid, if_id_pc, if_id_instr); end
        n_tests++; if (bus.imem_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_addr got %h exp 0", bus.imem_addr); end
        bus.imem_rvalid = 1'b0;
        step();
    endtask

    task automatic test_reset_in_wait();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hF000_0000;
        step();
        bus.imem_rvalid = 1'b0; stall = 1'b0;
        step();
        n_tests++; if (if_id_valid !== 1'b1 || bus.imem_addr !== 32'd4) begin n_fail++; $display("FAIL rw_pre got %b/%h exp 1/4", if_id_valid, bus.imem_addr); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (if_id_valid !== 1'b0 || if_id_instr !== c_NOP || if_id_pc !== 32'd0) begin n_fail++; $display("FAIL rw_async got %b/%h/%h exp 0/%h/0", if_id_valid, if_id_instr, if_id_pc, c_NOP); end
        n_tests++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'd0) begin n_fail++; $display("FAIL rw_async_bus got %b/%h exp 0/0", bus.imem_req, bus.imem_addr); end
        step();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_0001; stall = 1'b1;
        rst_n = 1'b1;
        step();
        n_tests++; if (if_id_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin n_fail++; $display("FAIL rw_restart got %b/%b/%h exp 0/1/0", if_id_valid, bus.imem_req, bus.imem_addr); end
        step();
        n_tests++; if (if_id_valid !== 1'b0 || if_id_instr !== c_NOP) begin n_fail++; $display("FAIL rw_late got %b/%h exp 0/%h", if_id_valid, if_id_instr, c_NOP); end
        bus.imem_rvalid = 1'b0;
        step();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1234_5678;
        step();
        n_tests++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h1234_5678 || if_id_pc !== 32'd0) begin n_fail++; $display("FAIL rw_fetch got %b/%h/%h exp 1/12345678/0", if_id_valid, if_id_instr, if_id_pc); end
        n_tests++; if (bus.imem_addr !== 32'd4) begin n_fail++; $display("FAIL rw_addr got %h exp 4", bus.imem_addr); end
        bus.imem_rvalid = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_sequential();
        test_hold();
        test_redirect_wait();
        test_flush_beats_stall();
        test_wrap();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
